// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_PRIO_EN to give requester 0 strict priority over the rotation.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [IDW-1:0]        last_q, last_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    cand;
  logic                  prio0;
  logic [IDW-1:0]        rr_win;

  assign eligible = req & ~ack_q;

`ifdef FIFO_ARB_PRIO_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign prio0 = eligible[0];
  assign cand  = eligible & ~NUM_REQ'(1);
`else
  assign prio0 = 1'b0;
  assign cand  = eligible;
`endif

  // First candidate after last_q, wrapping, so last_q ranks lowest.
  always_comb begin
    logic found;
    found  = 1'b0;
    rr_win = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx[IDW-1:0]]) begin
        found  = 1'b1;
        rr_win = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    logic [IDW-1:0] sel;
    state_d = state_q;
    ack_d   = '0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    last_d  = last_q;
    sel     = prio0 ? '0 : rr_win;
    unique case (state_q)
      IDLE: begin
        if (!fifo_full && (eligible != '0)) begin
          state_d = ISSUE;
          wr_d    = 1'b1;
          ack_d   = NUM_REQ'(1) << sel;
          wdata_d = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          gid_d   = sel;
          if (!prio0) last_d = sel;
        end
      end
      ISSUE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      gid_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  assign ack        = ack_q;
  assign fifo_wr    = wr_q;
  assign fifo_wdata = wdata_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q == ISSUE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 16-deep FIFO occupancy model.
// Build with FIFO_ARB_PRIO_EN defined to exercise the strict-priority variant.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic        fifo_rd;
  logic [4:0]  cnt_q = '0;
  logic [7:0]  log_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          writes;
  int          acks1;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_full = (cnt_q == 5'd16);

  always @(posedge clk) begin
    if (fifo_wr) begin
      log_q.push_back(fifo_wdata);
      n_cmp++;
      assert (cnt_q < 5'd16) else begin
        n_err++;
        $error("FAIL write_into_full: observed cnt %0d expected <16", cnt_q);
      end
    end
    cnt_q <= cnt_q + 5'(fifo_wr && cnt_q != 5'd16)
                   - 5'(fifo_rd && cnt_q != 5'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int g, input logic [7:0] d);
    @(negedge clk);
    chk("g_ack", 32'(ack), 32'(1 << g));
    chk("g_wr", 32'(fifo_wr), 32'd1);
    chk("g_gid", 32'(grant_id), 32'(g));
    chk("g_wdata", 32'(fifo_wdata), 32'(d));
    chk("g_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("i_ack", 32'(ack), 32'd0);
    chk("i_wr", 32'(fifo_wr), 32'd0);
    chk("i_busy", 32'(busy), 32'd0);
    chk("i_wdata_hold", 32'(fifo_wdata), 32'(d));
  endtask

  task automatic drain();
    fifo_rd = 1'b1;
    for (int i = 0; i < 40 && cnt_q != 0; i++) @(negedge clk);
    fifo_rd = 1'b0;
    chk("drain_cnt", 32'(cnt_q), 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    fifo_rd  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;

`ifdef FIFO_ARB_PRIO_EN
    expect_grant(0, 8'h10);
    expect_grant(0, 8'h10);
    expect_grant(0, 8'h10);
    req = 4'b1110;
    expect_grant(1, 8'h21);
    expect_grant(2, 8'h32);
    expect_grant(3, 8'h43);
    expect_grant(1, 8'h21);
    req = '0;
`else
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h21);
    expect_grant(2, 8'h32);
    expect_grant(3, 8'h43);
    expect_grant(0, 8'h10);
    req = '0;
    chk("rr_log_n", 32'(log_q.size()), 32'd5);
    chk("rr_log3", 32'(log_q[3]), 32'h43);

    // single requester, new data presented after the first ack
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    chk("s1_ack", 32'(ack), 32'b0100);
    chk("s1_wdata", 32'(fifo_wdata), 32'hA5);
    req_data[23:16] = 8'h5A;
    @(negedge clk);
    chk("s1_gap_wr", 32'(fifo_wr), 32'd0);
    @(negedge clk);
    chk("s2_ack", 32'(ack), 32'b0100);
    chk("s2_wdata", 32'(fifo_wdata), 32'h5A);
    req = '0;
    @(negedge clk);
    chk("s2_wr_low", 32'(fifo_wr), 32'd0);
    @(negedge clk);
    chk("s_nodup_wr", 32'(fifo_wr), 32'd0);
    chk("s_log_n", 32'(log_q.size()), 32'd7);
    chk("s_log5", 32'(log_q[5]), 32'hA5);
    chk("s_log6", 32'(log_q[6]), 32'h5A);

    // fill to full, then one read admits exactly one write
    drain();
    req = 4'b1111;
    writes = 0;
    repeat (40) begin
      @(negedge clk);
      if (fifo_wr) writes++;
    end
    chk("fill_writes", 32'(writes), 32'd16);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_wr_low", 32'(fifo_wr), 32'd0);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    writes = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_wr) writes++;
    end
    chk("one_more_writes", 32'(writes), 32'd1);
    chk("refull", 32'(fifo_full), 32'd1);
    req = '0;
    drain();

    // req[1] pulsed only while req[0] is being issued
    req = 4'b0001;
    @(negedge clk);
    chk("p_ack0", 32'(ack), 32'b0001);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    writes = 0;
    acks1 = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_wr) writes++;
      if (ack[1]) acks1++;
    end
    chk("p_no_ack1", 32'(acks1), 32'd0);
    chk("p_no_wr", 32'(writes), 32'd0);
`endif

    // async reset in the middle of ISSUE
    req = 4'b0001;
    @(negedge clk);
    chk("r_wr_before", 32'(fifo_wr), 32'd1);
    rst = 1'b0;
    #1;
    chk("r_ack_async", 32'(ack), 32'd0);
    chk("r_wr_async", 32'(fifo_wr), 32'd0);
    chk("r_busy_async", 32'(busy), 32'd0);
    req = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("r_ack3", 32'(ack), 32'b1000);
    chk("r_gid3", 32'(grant_id), 32'd3);
    chk("r_wr3", 32'(fifo_wr), 32'd1);
    req = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
